default_hash: RTL and testbench
===============================

DEFAULT_HASH -- requirements
Module: default_hash

Interface
REQ-001 Parameter ADDR_WIDTH, default 64: width of the address to hash and of the bucket output.
REQ-002 Parameter COE_A_INIT, default 32'h9E3779B1: reset value of multiplier coefficient coe_a (odd).
REQ-003 Parameter COE_B_INIT, default 32'h7F4A7C15: reset value of additive coefficient coe_b.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port update_valid  input  1: load a new bucket count this cycle.
REQ-007 Port num_buckets  input  33: requested bucket count, sampled when update_valid=1.
REQ-008 Port reseed  input  1: advance coe_a/coe_b to new pseudo-random values this cycle.
REQ-009 Port in_valid  input  1: hash request strobe.
REQ-010 Port in_addr  input  ADDR_WIDTH: address to hash.
REQ-011 Port out_valid  output  1: bucket result valid, exactly 2 cycles after in_valid.
REQ-012 Port out_bucket  output  ADDR_WIDTH: bucket index, zero-extended.
REQ-013 Ports lg_num_buckets (6), coe_a (32), coe_b (32)  output: current configuration registers.

Function
REQ-014 On update_valid, lg_num_buckets SHALL become ceil(log2(num_buckets)); num_buckets 0 or 1 -> 0; saturate at 32.
REQ-015 Fold: upper = in_addr[63:32], lower = in_addr[31:0], sva = upper XOR lower (32 bits).
REQ-016 Hash: h = (coe_a*sva + coe_b) mod 2^32; out_bucket = h >> (32 - lg_num_buckets); lg=0 -> out_bucket = 0 (no 32-bit shift artefact).
REQ-017 Pipeline: stage 1 registers sva, coe_a*sva (low 32 bits), coe_b and lg; stage 2 adds, shifts, registers output; throughput one request per cycle.
REQ-018 Configuration SHALL be captured with the request in stage 1; in-flight requests are unaffected by later update/reseed.
REQ-019 Same-cycle in_valid with update_valid or reseed: request uses the old configuration; new values visible the following cycle.
REQ-020 Reseed: coe_a <= LFSR32(coe_a) | 1; coe_b <= LFSR32(coe_b); LFSR32 is one step of a Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003).
REQ-021 update_valid and reseed in the same cycle SHALL both take effect.
REQ-022 out_bucket SHALL hold its last value when out_valid=0.

Reset
REQ-023 rst_n low SHALL immediately clear out_valid, pipeline valids, out_bucket, lg_num_buckets to 0 and load coe_a=COE_A_INIT, coe_b=COE_B_INIT.
REQ-024 Reset mid-operation SHALL discard in-flight requests; no out_valid for them.

Structure
REQ-025 Package hash_pkg SHALL hold ADDR_WIDTH, addr_bits typedef (logic [ADDR_WIDTH-1:0]), NUM_HASH_FUNC, LFSR mask and the ceil-log2 function.
REQ-026 One sub-module hash_lfsr32 (combinational next-state) is natural; everything else inline.

Verification
REQ-027 Reset, update num_buckets=1023, hash 64'hAAAAAAAABBBBBBBB -> lg_num_buckets=10, sva=32'h11111111, out_bucket=535 two cycles later.
REQ-028 num_buckets 1024 -> lg 10; 1025 -> lg 11; 0 and 1 -> lg 0 with out_bucket=0 for any address; 2^32 -> lg 32, out_bucket = full h.
REQ-029 Back-to-back in_valid for 8 cycles -> 8 consecutive out_valid pulses, results in order matching reference model.
REQ-030 Reseed from reset -> coe_a and coe_b equal one LFSR step of their init values, coe_a odd; hash in same cycle uses old coefficients.
REQ-031 Assert rst_n low while two requests in flight -> out_valid stays 0, registers return to init values asynchronously.

Source files
------------

// File: rtl/hash_pkg.sv
// Shared constants, types and helpers for the bucket hash.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hash_pkg;

    localparam int          ADDR_WIDTH    = 64;
    localparam int          NUM_HASH_FUNC = 1;
    localparam logic [31:0] LFSR_MASK     = 32'h80200003;

    typedef logic [ADDR_WIDTH-1:0] addr_bits;

    // Smallest k with 2^k >= n; 0 and 1 map to 0, anything above 2^32 saturates at 32.
    function automatic logic [5:0] ceil_log2(input logic [32:0] n);
        logic [32:0] m;
        logic [5:0]  r;
        m = n - 33'd1;
        r = 6'd0;
        if (n > 33'd1) begin
            for (int i = 0; i < 33; i++) begin
                if (m[i]) r = 6'(i + 1);
            end
        end
        if (r > 6'd32) r = 6'd32;
        return r;
    endfunction

endpackage

// File: rtl/hash_lfsr32.sv
// One step of the 32-bit Galois LFSR used to derive fresh hash coefficients.
// Latency: combinational.
// Backpressure: none.
module hash_lfsr32
    import hash_pkg::*;
(
    input  logic [31:0] cur,
    output logic [31:0] nxt
);

    // Shift right and fold the polynomial taps back in when a one drops out.
    always_comb begin
        nxt = (cur >> 1) ^ (cur[0] ? LFSR_MASK : 32'd0);
    end

endmodule

// File: rtl/default_hash.sv
// Multiplicative hash of an address into 2^lg_num_buckets buckets, reseedable coefficients.
// Latency: 2 cycles from in_valid to out_valid, one request per cycle.
// Backpressure: none; the pipeline always accepts and always delivers.
module default_hash
    import hash_pkg::*;
#(
    parameter int          ADDR_WIDTH = hash_pkg::ADDR_WIDTH,
    parameter logic [31:0] COE_A_INIT = 32'h9E3779B1,
    parameter logic [31:0] COE_B_INIT = 32'h7F4A7C15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  update_valid,
    input  logic [32:0]           num_buckets,
    input  logic                  reseed,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_bucket,
    output logic [5:0]            lg_num_buckets,
    output logic [31:0]           coe_a,
    output logic [31:0]           coe_b
);

    logic [63:0] addr_ext;
    logic [31:0] sva;
    logic [31:0] prod;
    logic [31:0] coe_a_nxt;
    logic [31:0] coe_b_nxt;

    logic        s1_vld;
    logic [31:0] s1_prod;
    logic [31:0] s1_coe_b;
    logic [5:0]  s1_lg;

    logic [31:0] h;
    logic [31:0] bucket32;

    // Fold the address down to 32 bits and take the low half of the product.
    assign addr_ext = 64'(in_addr);
    assign sva      = addr_ext[63:32] ^ addr_ext[31:0];
    assign prod     = coe_a * sva;

    hash_lfsr32 u_lfsr_a (
        .cur (coe_a),
        .nxt (coe_a_nxt)
    );

    hash_lfsr32 u_lfsr_b (
        .cur (coe_b),
        .nxt (coe_b_nxt)
    );

    // Configuration registers; update and reseed are independent and may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lg_num_buckets <= 6'd0;
            coe_a          <= COE_A_INIT;
            coe_b          <= COE_B_INIT;
        end else begin
            if (update_valid) begin
                lg_num_buckets <= ceil_log2(num_buckets);
            end
            if (reseed) begin
                coe_a <= coe_a_nxt | 32'd1;
                coe_b <= coe_b_nxt;
            end
        end
    end

    // Stage 1: snapshot the configuration with the request so later changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_prod  <= 32'd0;
            s1_coe_b <= 32'd0;
            s1_lg    <= 6'd0;
        end else begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_prod  <= prod;
                s1_coe_b <= coe_b;
                s1_lg    <= lg_num_buckets;
            end
        end
    end

    // Stage 2 datapath: add the offset and keep the top lg bits; lg of zero means a single bucket.
    always_comb begin
        h        = s1_prod + s1_coe_b;
        bucket32 = 32'd0;
        if (s1_lg != 6'd0) begin
            bucket32 = h >> (6'd32 - s1_lg);
        end
    end

    // Stage 2 register: the bucket holds its value between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_bucket <= '0;
        end else begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_bucket <= ADDR_WIDTH'(bucket32);
            end
        end
    end

endmodule

// File: tb/tb_default_hash.sv
// Randomized scoreboard bench for default_hash against a behavioural model.
// Latency: checks results exactly two cycles after each request.
// Backpressure: none exercised; the design has none.
module tb_default_hash;
    import hash_pkg::*;

    localparam logic [31:0] A0 = 32'h9E3779B1;
    localparam logic [31:0] B0 = 32'h7F4A7C15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        update_valid = 1'b0;
    logic [32:0] num_buckets = 33'd0;
    logic        reseed = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_addr = 64'd0;
    logic        out_valid;
    logic [63:0] out_bucket;
    logic [5:0]  lg_num_buckets;
    logic [31:0] coe_a;
    logic [31:0] coe_b;

    default_hash dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .update_valid   (update_valid),
        .num_buckets    (num_buckets),
        .reseed         (reseed),
        .in_valid       (in_valid),
        .in_addr        (in_addr),
        .out_valid      (out_valid),
        .out_bucket     (out_bucket),
        .lg_num_buckets (lg_num_buckets),
        .coe_a          (coe_a),
        .coe_b          (coe_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] b;
        int          due;
    } exp_t;
    exp_t q[$];

    logic [5:0]  m_lg = 6'd0;
    logic [31:0] m_a = A0;
    logic [31:0] m_b = B0;
    logic [63:0] last_b = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bucket count as a power of two: double until it covers n, capped at 32 doublings.
    function automatic logic [5:0] ref_lg(input logic [32:0] n);
        logic [33:0] p;
        int          k;
        p = 34'd1;
        k = 0;
        while (p < {1'b0, n} && k < 32) begin
            p = p * 2;
            k++;
        end
        return 6'(k);
    endfunction

    function automatic logic [31:0] ref_lfsr(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 32'h80200003;
        return y;
    endfunction

    // Bucket = top lg bits of the 32-bit hash, computed by integer division.
    function automatic logic [63:0] ref_bucket(input logic [63:0] addr, input logic [5:0] lg,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [63:0] s;
        logic [63:0] h;
        s = {32'd0, addr[63:32] ^ addr[31:0]};
        h = ({32'd0, a} * s + {32'd0, b}) % 64'h1_0000_0000;
        if (lg == 6'd0) return 64'd0;
        return h / (64'd1 << (32 - int'(lg)));
    endfunction

    // One clock of stimulus; expected result uses the configuration in force before this edge.
    task automatic step(input logic uv, input logic [32:0] nb, input logic rs, input logic iv,
                        input logic [63:0] addr, input longint ovr);
        exp_t e;
        update_valid = uv;
        num_buckets  = nb;
        reseed       = rs;
        in_valid     = iv;
        in_addr      = addr;
        if (iv) begin
            e.b   = (ovr >= 0) ? 64'(ovr) : ref_bucket(addr, m_lg, m_a, m_b);
            e.due = cyc + 2;
            q.push_back(e);
        end
        if (uv) m_lg = ref_lg(nb);
        if (rs) begin
            m_a = ref_lfsr(m_a) | 32'd1;
            m_b = ref_lfsr(m_b);
        end
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        reseed       = 1'b0;
        in_valid     = 1'b0;
        chk("lg_num_buckets", 64'(lg_num_buckets), 64'(m_lg));
        chk("coe_a", 64'(coe_a), 64'(m_a));
        chk("coe_b", 64'(coe_b), 64'(m_b));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 33'd0, 1'b0, 1'b0, 64'd0, -1);
    endtask

    // Asynchronous reset: values must be back to init before any clock edge.
    task automatic do_reset();
        q.delete();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_bucket", out_bucket, 64'd0);
        chk("rst_lg", 64'(lg_num_buckets), 64'd0);
        chk("rst_coe_a", 64'(coe_a), 64'(A0));
        chk("rst_coe_b", 64'(coe_b), 64'(B0));
        chk("rst_s1_vld", 64'(dut.s1_vld), 64'd0);
        m_lg   = 6'd0;
        m_a    = A0;
        m_b    = B0;
        last_b = 64'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every cycle against the front of the scoreboard.
    always @(negedge clk) begin
        logic ev;
        if (q.size() > 0 && q[0].due < cyc) begin
            chk("latency", 64'(q[0].due), 64'(cyc));
            void'(q.pop_front());
        end
        ev = (q.size() > 0) && (q[0].due == cyc);
        if (ev) begin
            chk("out_valid", 64'(out_valid), 64'd1);
            chk("out_bucket", out_bucket, q[0].b);
            last_b = q[0].b;
            void'(q.pop_front());
        end else if (out_valid) begin
            chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
            chk("hold_bucket", out_bucket, last_b);
        end
    end

    initial begin
        logic [63:0] a;
        @(posedge clk);
        #1;
        do_reset();

        // Directed reference point: 1023 buckets, folded address 0x11111111.
        step(1'b1, 33'd1023, 1'b0, 1'b0, 64'd0, -1);
        chk("lg_1023", 64'(lg_num_buckets), 64'd10);
        a = 64'hAAAAAAAABBBBBBBB;
        in_addr = a;
        #1;
        chk("sva", 64'(dut.sva), 64'h11111111);
        step(1'b0, 33'd0, 1'b0, 1'b1, a, 535);
        idle(3);

        // Bucket-count boundaries with hashes under each.
        step(1'b1, 33'd1024, 1'b0, 1'b0, 64'd0, -1);
        chk("lg_1024", 64'(lg_num_buckets), 64'd10);
        step(1'b0, 33'd0, 1'b0, 1'b1, {$urandom, $urandom}, -1);
        step(1'b1, 33'd1025, 1'b0, 1'b0, 64'd0, -1);
        chk("lg_1025", 64'(lg_num_buckets), 64'd11);
        step(1'b0, 33'd0, 1'b0, 1'b1, {$urandom, $urandom}, -1);
        step(1'b1, 33'd0, 1'b0, 1'b0, 64'd0, -1);
        chk("lg_0", 64'(lg_num_buckets), 64'd0);
        step(1'b0, 33'd0, 1'b0, 1'b1, {$urandom, $urandom}, 0);
        step(1'b0, 33'd0, 1'b0, 1'b1, 64'hFFFFFFFF00000000, 0);
        step(1'b1, 33'd1, 1'b0, 1'b0, 64'd0, -1);
        chk("lg_1", 64'(lg_num_buckets), 64'd0);
        step(1'b0, 33'd0, 1'b0, 1'b1, {$urandom, $urandom}, 0);
        step(1'b1, 33'h1_0000_0000, 1'b0, 1'b0, 64'd0, -1);
        chk("lg_2p32", 64'(lg_num_buckets), 64'd32);
        step(1'b0, 33'd0, 1'b0, 1'b1, a, 64'h85CF51D6);
        step(1'b0, 33'd0, 1'b0, 1'b1, {$urandom, $urandom}, -1);
        idle(3);

        // Eight back-to-back requests.
        step(1'b1, 33'd5000, 1'b0, 1'b0, 64'd0, -1);
        for (int i = 0; i < 8; i++) step(1'b0, 33'd0, 1'b0, 1'b1, {$urandom, $urandom}, -1);
        idle(3);

        // Reseed from reset with a request in the same cycle.
        do_reset();
        step(1'b1, 33'd256, 1'b0, 1'b0, 64'd0, -1);
        step(1'b0, 33'd0, 1'b1, 1'b1, {$urandom, $urandom}, -1);
        chk("reseed_coe_a", 64'(coe_a), 64'(ref_lfsr(A0) | 32'd1));
        chk("reseed_coe_b", 64'(coe_b), 64'(ref_lfsr(B0)));
        chk("coe_a_odd", 64'(coe_a[0]), 64'd1);
        step(1'b0, 33'd0, 1'b0, 1'b1, {$urandom, $urandom}, -1);

        // Update and reseed together while a request is issued.
        step(1'b1, 33'd70000, 1'b1, 1'b1, {$urandom, $urandom}, -1);
        step(1'b0, 33'd0, 1'b0, 1'b1, {$urandom, $urandom}, -1);
        idle(3);

        // Random mix of configuration changes and requests.
        for (int i = 0; i < 300; i++) begin
            logic [32:0] nb;
            nb = {1'b0, $urandom} >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) nb = 33'h1_0000_0000;
            step(($urandom_range(0, 3) == 0), nb, ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) != 0), {$urandom, $urandom}, -1);
        end
        idle(3);

        // Reset while requests are in flight: nothing may come out.
        step(1'b1, 33'd300, 1'b0, 1'b1, {$urandom, $urandom}, -1);
        in_valid = 1'b1;
        in_addr  = {$urandom, $urandom};
        #2;
        do_reset();
        idle(4);
        step(1'b1, 33'd64, 1'b0, 1'b1, {$urandom, $urandom}, -1);
        step(1'b0, 33'd0, 1'b0, 1'b1, {$urandom, $urandom}, -1);
        idle(4);

        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
